fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage RV32 pipeline, directly upstream of the execute-stage branch resolution. It owns the fetch PC and a request/ready handshake to instruction memory, and fills the IF/ID pipeline register. It also applies redirects from the execute stage (`PCSrcE`/`PCTargetE`), so wrong-path fetches are discarded even when a memory access is still outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `PCSrcE`  in  1  execute-stage redirect (taken branch or jump).
- `PCTargetE`  in  32  redirect target; bits [1:0] ignored and forced to 00.
- `StallF`  in  1  hazard-unit fetch stall.
- `StallD`  in  1  hazard-unit decode stall (holds IF/ID).
- `FlushD`  in  1  hazard-unit IF/ID flush.
- `ImemReq`  out  1  instruction-memory request.
- `ImemAddr`  out  32  request address; stable while `ImemReq`=1 and `ImemRdy`=0.
- `ImemRdy`  in  1  response valid this cycle; may be asserted in the same cycle as `ImemReq`.
- `ImemRData`  in  32  instruction word, valid when `ImemRdy`=1.
- `PCF`  out  32  address currently being fetched (equals `ImemAddr`).
- `InstrD`, `PCD`, `PCPlus4D`  out  32 each  IF/ID register contents.
- `ValidD`  out  1  IF/ID holds a real instruction.

## Operation
- Registers:
  - `FetchAddr`, driving `ImemAddr` and `PCF`.
  - `RedirAddr`.
  - `InstrBuf`.
  - FSM state.
  - IF/ID register.
- `Stall` = `StallF` | `StallD`.
- A **delivery** writes `InstrD`, `PCD`=`FetchAddr`, `PCPlus4D`=`FetchAddr`+4 and `ValidD`=1.
- IF/ID update priority each cycle:
  1. `FlushD` or `PCSrcE`: `ValidD`←0, `InstrD`←`NOP_INSTR`; `PCD` and `PCPlus4D` hold.
  2. `StallD`: hold.
  3. Delivery.
  4. Otherwise bubble: `ValidD`←0, `InstrD`←`NOP_INSTR`.
- FSM states:
  - **IDLE**: `ImemReq`=0; always goes to FETCH next cycle.
  - **FETCH**: `ImemReq`=1.
    - `PCSrcE` and `ImemRdy`: drop the response; `FetchAddr`←target; stay in FETCH.
    - `PCSrcE` and not `ImemRdy`: `RedirAddr`←target; go to DRAIN.
    - `ImemRdy`, no `Stall`: deliver `ImemRData`; `FetchAddr`+=4; stay in FETCH.
    - `ImemRdy` with `Stall`: `InstrBuf`←`ImemRData`; go to HOLD.
    - Otherwise: wait, keeping the address stable.
  - **HOLD**: `ImemReq`=0.
    - `PCSrcE`: discard `InstrBuf`; `FetchAddr`←target; go to FETCH.
    - No `Stall`: deliver `InstrBuf`; `FetchAddr`+=4; go to FETCH.
    - Otherwise: stay in HOLD.
  - **DRAIN**: `ImemReq`=1 with the old address, because the outstanding request must complete.
    - A further `PCSrcE` overwrites `RedirAddr` (latest target wins).
    - On `ImemRdy`: discard the response; `FetchAddr`←(`PCSrcE` ? `PCTargetE` : `RedirAddr`); go to FETCH.
- Arithmetic: `FetchAddr`+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values (asynchronous):
  - State IDLE.
  - `FetchAddr`=`RESET_PC`, `RedirAddr`=0, `InstrBuf`=`NOP_INSTR`.
  - `ImemReq`=0.
  - `ValidD`=0, `InstrD`=`NOP_INSTR`, `PCD`=0, `PCPlus4D`=0.
- Reset asserted mid-request: the request is abandoned and `ImemReq` drops immediately.
- First `ImemReq` occurs one cycle after `reset` deasserts.
- Zero-wait memory (`ImemRdy` in the request cycle): one instruction per cycle; the instruction at address A appears in `InstrD` the cycle after `ImemAddr`=A.
- N wait cycles: N+1 cycles per instruction; bubbles are inserted in IF/ID.
- Redirect: `PCSrcE` in cycle n gives `ImemAddr`=`PCTargetE` in cycle n+1 from FETCH/HOLD, or the cycle after `ImemRdy` from DRAIN.
- No wrong-path instruction ever reaches IF/ID with `ValidD`=1.

## Test plan
- **Reset and sequential fetch:** `RESET_PC`=0x100, zero-wait memory → `ImemAddr` sequence 0x100, 0x104, 0x108; `InstrD`/`PCD` follow one cycle later, with `ValidD`=1 from the second post-reset cycle onward.
- **Wait states:** `ImemRdy` delayed 2 cycles per access → `ImemAddr` held for 3 cycles; `ValidD`=1 for one cycle in every 3.
- **Stall:** `StallF`=`StallD`=1 for 3 cycles while a response arrives → HOLD entered; IF/ID unchanged; `ImemReq`=0; on release the buffered word is delivered with the correct `PCD` and nothing is lost or duplicated.
- **Redirect during an outstanding request:** `PCSrcE`=1, `PCTargetE`=0x200 while 0x10C waits → 0x10C response discarded; next `ImemAddr`=0x200; `ValidD` stays 0 until 0x200 is delivered.
- **Double redirect in DRAIN:** targets 0x200, then 0x300, before `ImemRdy` → the next fetch is 0x300.
- **Wrap and flush:** fetch from 0xFFFF_FFFC → next address 0x0000_0000 with `PCPlus4D`=0; `FlushD` pulse → `ValidD`=0 and `InstrD`=0x0000_0013 on the next edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// Ports: ImemReq/ImemAddr (fetch -> imem), ImemRdy/ImemRData (imem -> fetch).
// master = fetch stage side, slave = instruction-memory side.
interface fetch_stage_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemRdy;
    logic [31:0] ImemRData;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemRdy,
        input  ImemRData
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemRdy,
        output ImemRData
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: owns the fetch PC, talks to imem, fills IF/ID.
// Latency: the word at address A reaches InstrD the cycle after ImemRdy for A
// (one instr/cycle on zero-wait memory).
// Backpressure: StallF|StallD parks a returned word in a buffer (HOLD);
// redirects during an outstanding access drain it first.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   PCSrcE, PCTargetE   execute-stage redirect and target (bits [1:0] ignored)
//   StallF, StallD      hazard-unit stalls; FlushD clears IF/ID
//   imem                request/ready instruction-memory handshake (master)
//   PCF                 address currently being fetched (== ImemAddr)
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register contents
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PCSrcE,
    input  logic [31:0]          PCTargetE,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 FlushD,
    fetch_stage_if.master        imem,
    output logic [31:0]          PCF,
    output logic [31:0]          InstrD,
    output logic [31:0]          PCD,
    output logic [31:0]          PCPlus4D,
    output logic                 ValidD
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_addr;
    logic [31:0] r_redir_addr;
    logic [31:0] r_instr_buf;
    logic        r_imem_req;

    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pcplus4_d;
    logic        r_valid_d;

    logic        w_stall;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic        w_deliver;
    logic [31:0] w_deliver_instr;
    logic        w_unused_tgt_lsbs;

    assign w_stall    = StallF | StallD;
    // Instructions are word aligned; the low target bits carry no information.
    assign w_target   = {PCTargetE[31:2], 2'b00};
    assign w_pc_plus4 = r_fetch_addr + 32'd4;   // wraps modulo 2^32
    assign w_unused_tgt_lsbs = ^PCTargetE[1:0];

    // A delivery happens when a word for the current FetchAddr is available
    // (live from memory in FETCH, buffered in HOLD), no redirect kills it and
    // the pipeline is free to accept it.
    always_comb begin
        w_deliver       = 1'b0;
        w_deliver_instr = imem.ImemRData;
        case (r_state)
            ST_FETCH: w_deliver = imem.ImemRdy & ~PCSrcE & ~w_stall;
            ST_HOLD: begin
                w_deliver       = ~PCSrcE & ~w_stall;
                w_deliver_instr = r_instr_buf;
            end
            default: w_deliver = 1'b0;
        endcase
    end

    // Fetch FSM. ImemReq is registered and follows the next state, so it is
    // high exactly in FETCH and DRAIN and drops at once on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_fetch_addr <= RESET_PC;
            r_redir_addr <= 32'h0000_0000;
            r_instr_buf  <= NOP_INSTR;
            r_imem_req   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                end

                ST_FETCH: begin
                    if (PCSrcE) begin
                        if (imem.ImemRdy) begin
                            // Access already finished: drop it and retarget now.
                            r_fetch_addr <= w_target;
                        end else begin
                            // Access still in flight: must let it complete on
                            // the old address before switching.
                            r_redir_addr <= w_target;
                            r_state      <= ST_DRAIN;
                        end
                    end else if (imem.ImemRdy) begin
                        if (!w_stall) begin
                            r_fetch_addr <= w_pc_plus4;
                        end else begin
                            r_instr_buf <= imem.ImemRData;
                            r_state     <= ST_HOLD;
                            r_imem_req  <= 1'b0;
                        end
                    end
                end

                ST_HOLD: begin
                    if (PCSrcE) begin
                        r_instr_buf  <= NOP_INSTR;
                        r_fetch_addr <= w_target;
                        r_state      <= ST_FETCH;
                        r_imem_req   <= 1'b1;
                    end else if (!w_stall) begin
                        r_fetch_addr <= w_pc_plus4;
                        r_state      <= ST_FETCH;
                        r_imem_req   <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (imem.ImemRdy) begin
                        // Wrong-path response is discarded; a redirect in this
                        // same cycle is newer than the saved one.
                        r_fetch_addr <= PCSrcE ? w_target : r_redir_addr;
                        r_state      <= ST_FETCH;
                    end else if (PCSrcE) begin
                        r_redir_addr <= w_target;
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register. Flush/redirect beats stall, stall beats delivery.
    // On a kill the PC fields keep their last values; only ValidD matters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_d   <= 1'b0;
            r_instr_d   <= NOP_INSTR;
            r_pc_d      <= 32'h0000_0000;
            r_pcplus4_d <= 32'h0000_0000;
        end else if (FlushD || PCSrcE) begin
            r_valid_d <= 1'b0;
            r_instr_d <= NOP_INSTR;
        end else if (StallD) begin
            r_valid_d <= r_valid_d;
        end else if (w_deliver) begin
            r_valid_d   <= 1'b1;
            r_instr_d   <= w_deliver_instr;
            r_pc_d      <= r_fetch_addr;
            r_pcplus4_d <= w_pc_plus4;
        end else begin
            r_valid_d <= 1'b0;
            r_instr_d <= NOP_INSTR;
        end
    end

    assign imem.ImemReq  = r_imem_req;
    assign imem.ImemAddr = r_fetch_addr;
    assign PCF           = r_fetch_addr;
    assign InstrD        = r_instr_d;
    assign PCD           = r_pc_d;
    assign PCPlus4D      = r_pcplus4_d;
    assign ValidD        = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, wait states, stall,
// redirects (FETCH, DRAIN, double), address wrap, flush and mid-run reset.
// Memory returns instr_of(addr) after mem_wait cycles; mem_block holds it off.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int vectors;
    int miscompares;
    int mem_wait;
    int mem_block;
    int cnt;

    fetch_stage_if imem ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0100),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .imem      (imem),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: counts wait cycles of the current request.
    assign imem.ImemRdy   = imem.ImemReq && (mem_block == 0) && (cnt >= mem_wait);
    assign imem.ImemRData = instr_of(imem.ImemAddr);

    always @(posedge clk) begin
        if (imem.ImemReq && !imem.ImemRdy) cnt <= cnt + 1;
        else                               cnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0; miscompares = 0;
        mem_wait = 0; mem_block = 0; cnt = 0;
        reset = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'h0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;

        tick(); tick();
        // Reset state
        chk("rst_req",    {31'd0, imem.ImemReq}, 32'd0);
        chk("rst_pcf",    PCF,                   32'h0000_0100);
        chk("rst_valid",  {31'd0, ValidD},       32'd0);
        chk("rst_instr",  InstrD,                32'h0000_0013);
        chk("rst_pcd",    PCD,                   32'h0);
        chk("rst_pcp4",   PCPlus4D,              32'h0);
        reset = 1'b0;

        // t1: first request one cycle after reset release
        tick();
        chk("t1_req",   {31'd0, imem.ImemReq}, 32'd1);
        chk("t1_addr",  imem.ImemAddr,         32'h0000_0100);
        chk("t1_valid", {31'd0, ValidD},       32'd0);
        // t2..t4: zero-wait sequential fetch
        tick();
        chk("t2_instr", InstrD,   instr_of(32'h100));
        chk("t2_pcd",   PCD,      32'h100);
        chk("t2_pcp4",  PCPlus4D, 32'h104);
        chk("t2_valid", {31'd0, ValidD}, 32'd1);
        chk("t2_addr",  imem.ImemAddr, 32'h104);
        tick();
        chk("t3_instr", InstrD, instr_of(32'h104));
        chk("t3_addr",  PCF,    32'h108);
        tick();
        chk("t4_instr", InstrD, instr_of(32'h108));
        chk("t4_pcd",   PCD,    32'h108);
        chk("t4_addr",  PCF,    32'h10C);

        // Wait states: two wait cycles per access
        mem_wait = 2;
        tick();
        chk("w5_valid", {31'd0, ValidD}, 32'd0);
        chk("w5_addr",  PCF, 32'h10C);
        tick();
        chk("w6_valid", {31'd0, ValidD}, 32'd0);
        chk("w6_addr",  PCF, 32'h10C);
        tick();
        chk("w7_valid", {31'd0, ValidD}, 32'd1);
        chk("w7_instr", InstrD, instr_of(32'h10C));
        chk("w7_pcd",   PCD,    32'h10C);
        chk("w7_addr",  PCF,    32'h110);

        // Stall for three cycles while 0x110 returns
        StallF = 1'b1; StallD = 1'b1;
        tick();
        chk("s8_instr", InstrD, instr_of(32'h10C));
        chk("s8_valid", {31'd0, ValidD}, 32'd1);
        tick();
        chk("s9_req",   {31'd0, imem.ImemReq}, 32'd1);
        chk("s9_pcd",   PCD, 32'h10C);
        tick();
        chk("s10_req",   {31'd0, imem.ImemReq}, 32'd0);
        chk("s10_instr", InstrD, instr_of(32'h10C));
        chk("s10_pcd",   PCD, 32'h10C);
        StallF = 1'b0; StallD = 1'b0;
        tick();
        chk("s11_instr", InstrD,   instr_of(32'h110));
        chk("s11_pcd",   PCD,      32'h110);
        chk("s11_pcp4",  PCPlus4D, 32'h114);
        chk("s11_valid", {31'd0, ValidD}, 32'd1);
        chk("s11_req",   {31'd0, imem.ImemReq}, 32'd1);
        chk("s11_addr",  PCF, 32'h114);

        // Redirect to 0x200 while 0x114 is outstanding
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
        tick();
        chk("r12_addr",  PCF, 32'h114);
        chk("r12_req",   {31'd0, imem.ImemReq}, 32'd1);
        chk("r12_valid", {31'd0, ValidD}, 32'd0);
        chk("r12_instr", InstrD, 32'h13);
        chk("r12_pcd",   PCD, 32'h110);
        PCSrcE = 1'b0;
        tick();
        chk("r13_addr",  PCF, 32'h114);
        chk("r13_valid", {31'd0, ValidD}, 32'd0);
        tick();
        chk("r14_addr",  PCF, 32'h200);
        chk("r14_valid", {31'd0, ValidD}, 32'd0);
        mem_wait = 0;
        tick();
        chk("r15_instr", InstrD, instr_of(32'h200));
        chk("r15_pcd",   PCD, 32'h200);
        chk("r15_valid", {31'd0, ValidD}, 32'd1);

        // Double redirect in DRAIN: 0x400 then 0x303 (low bits dropped)
        mem_block = 1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0400;
        tick();
        chk("d16_addr",  PCF, 32'h204);
        chk("d16_valid", {31'd0, ValidD}, 32'd0);
        PCTargetE = 32'h0000_0303;
        tick();
        chk("d17_addr", PCF, 32'h204);
        chk("d17_req",  {31'd0, imem.ImemReq}, 32'd1);
        PCSrcE = 1'b0; mem_block = 0;
        tick();
        chk("d18_addr",  PCF, 32'h300);
        chk("d18_valid", {31'd0, ValidD}, 32'd0);
        tick();
        chk("d19_instr", InstrD,   instr_of(32'h300));
        chk("d19_pcp4",  PCPlus4D, 32'h304);
        chk("d19_addr",  PCF,      32'h304);

        // Redirect coinciding with ImemRdy in FETCH, to the top word
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        tick();
        chk("x20_addr",  PCF, 32'hFFFF_FFFC);
        chk("x20_valid", {31'd0, ValidD}, 32'd0);
        chk("x20_pcd",   PCD, 32'h300);
        PCSrcE = 1'b0;
        tick();
        chk("x21_instr", InstrD,   instr_of(32'hFFFF_FFFC));
        chk("x21_pcd",   PCD,      32'hFFFF_FFFC);
        chk("x21_pcp4",  PCPlus4D, 32'h0);
        chk("x21_addr",  PCF,      32'h0);

        // Flush pulse
        FlushD = 1'b1;
        tick();
        chk("f22_valid", {31'd0, ValidD}, 32'd0);
        chk("f22_instr", InstrD, 32'h13);
        chk("f22_pcd",   PCD, 32'hFFFF_FFFC);
        chk("f22_addr",  PCF, 32'h4);
        FlushD = 1'b0;
        tick();
        chk("f23_instr", InstrD, instr_of(32'h4));
        chk("f23_valid", {31'd0, ValidD}, 32'd1);

        // Asynchronous reset in the middle of a request
        reset = 1'b1;
        #1;
        chk("ar_req",   {31'd0, imem.ImemReq}, 32'd0);
        chk("ar_pcf",   PCF, 32'h100);
        chk("ar_valid", {31'd0, ValidD}, 32'd0);
        chk("ar_instr", InstrD, 32'h13);
        tick();
        reset = 1'b0;
        tick();
        chk("ar2_req",  {31'd0, imem.ImemReq}, 32'd1);
        chk("ar2_addr", imem.ImemAddr, 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
